ex_mem_wb_pipe: RTL and testbench

- EX/MEM and MEM/WB pipeline registers plus the data-memory access sequencer for the 16-register pipelined CPU.
- Sits between the EX stage and write-back.
- Sources EX_MEM_regWrite, EX_MEM_rd, MEM_WB_regWrite and MEM_WB_rd, which the forwarding control consumes.
- Stalls the upstream pipeline while a data-memory access is outstanding.

---
 rtl/ex_mem_wb_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_ex_mem_wb_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with a data-memory sequencer that stalls EX while an access is outstanding.
// Optional stall-cycle counter output enabled by defining EX_MEM_STALL_COUNT_EN.
module ex_mem_wb_pipe #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_regWrite,
    input  logic              ex_memRead,
    input  logic              ex_memWrite,
    input  logic              ex_memToReg,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [DATA_W-1:0] ex_aluResult,
    input  logic [DATA_W-1:0] ex_storeData,
    input  logic              flush,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              ex_stall,
    output logic              EX_MEM_regWrite,
    output logic [REG_W-1:0]  EX_MEM_rd,
    output logic [DATA_W-1:0] EX_MEM_aluResult,
    output logic              MEM_WB_regWrite,
    output logic [REG_W-1:0]  MEM_WB_rd,
    output logic [DATA_W-1:0] MEM_WB_writeData
`ifdef EX_MEM_STALL_COUNT_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e              state_q, state_d;

    logic                ex_mem_valid_q, ex_mem_valid_d;
    logic                ex_mem_regWrite_q, ex_mem_regWrite_d;
    logic                ex_mem_memRead_q, ex_mem_memRead_d;
    logic                ex_mem_memWrite_q, ex_mem_memWrite_d;
    logic                ex_mem_memToReg_q, ex_mem_memToReg_d;
    logic [REG_W-1:0]    ex_mem_rd_q, ex_mem_rd_d;
    logic [DATA_W-1:0]   ex_mem_alu_q, ex_mem_alu_d;
    logic [DATA_W-1:0]   ex_mem_store_q, ex_mem_store_d;

    logic                mem_wb_valid_q, mem_wb_valid_d;
    logic                mem_wb_regWrite_q, mem_wb_regWrite_d;
    logic [REG_W-1:0]    mem_wb_rd_q, mem_wb_rd_d;
    logic [DATA_W-1:0]   mem_wb_data_q, mem_wb_data_d;

    logic                memop_s;
    logic                stall_s;
    logic                ex_take_s;

    // Memory interface and stall are combinational so a same-cycle ack costs no wait state.
    always_comb begin
        memop_s  = ex_mem_valid_q & (ex_mem_memRead_q | ex_mem_memWrite_q);
        mem_req  = memop_s | (state_q == ST_WAIT);
        stall_s  = mem_req & ~mem_ack;
        ex_stall = stall_s;
        mem_we   = ex_mem_memWrite_q;
        mem_addr = ex_mem_alu_q;
        mem_wdata = ex_mem_store_q;
    end

    // Sequencer next state: RUN waits only when an access is not acked in its first cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (memop_s && !mem_ack) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Pipeline register next values: advance both stages, or hold EX/MEM and bubble MEM/WB.
    always_comb begin
        ex_take_s         = ex_valid & ~flush;
        ex_mem_valid_d    = ex_mem_valid_q;
        ex_mem_regWrite_d = ex_mem_regWrite_q;
        ex_mem_memRead_d  = ex_mem_memRead_q;
        ex_mem_memWrite_d = ex_mem_memWrite_q;
        ex_mem_memToReg_d = ex_mem_memToReg_q;
        ex_mem_rd_d       = ex_mem_rd_q;
        ex_mem_alu_d      = ex_mem_alu_q;
        ex_mem_store_d    = ex_mem_store_q;
        mem_wb_valid_d    = 1'b0;
        mem_wb_regWrite_d = 1'b0;
        mem_wb_rd_d       = mem_wb_rd_q;
        mem_wb_data_d     = mem_wb_data_q;
        if (!stall_s) begin
            mem_wb_valid_d    = ex_mem_valid_q;
            mem_wb_regWrite_d = ex_mem_valid_q & ex_mem_regWrite_q;
            mem_wb_rd_d       = ex_mem_rd_q;
            if (ex_mem_memToReg_q) begin
                mem_wb_data_d = mem_rdata;
            end else begin
                mem_wb_data_d = ex_mem_alu_q;
            end
            ex_mem_valid_d    = ex_take_s;
            ex_mem_regWrite_d = ex_take_s & ex_regWrite;
            ex_mem_memRead_d  = ex_take_s & ex_memRead;
            ex_mem_memWrite_d = ex_take_s & ex_memWrite;
            ex_mem_memToReg_d = ex_memToReg;
            ex_mem_rd_d       = ex_rd;
            ex_mem_alu_d      = ex_aluResult;
            ex_mem_store_d    = ex_storeData;
        end else begin
            mem_wb_valid_d    = 1'b0;
            mem_wb_regWrite_d = 1'b0;
        end
    end

    // State registers with synchronous reset; reset also abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= ST_RUN;
            ex_mem_valid_q    <= 1'b0;
            ex_mem_regWrite_q <= 1'b0;
            ex_mem_memRead_q  <= 1'b0;
            ex_mem_memWrite_q <= 1'b0;
            ex_mem_memToReg_q <= 1'b0;
            ex_mem_rd_q       <= {REG_W{1'b0}};
            ex_mem_alu_q      <= {DATA_W{1'b0}};
            ex_mem_store_q    <= {DATA_W{1'b0}};
            mem_wb_valid_q    <= 1'b0;
            mem_wb_regWrite_q <= 1'b0;
            mem_wb_rd_q       <= {REG_W{1'b0}};
            mem_wb_data_q     <= {DATA_W{1'b0}};
        end else begin
            state_q           <= state_d;
            ex_mem_valid_q    <= ex_mem_valid_d;
            ex_mem_regWrite_q <= ex_mem_regWrite_d;
            ex_mem_memRead_q  <= ex_mem_memRead_d;
            ex_mem_memWrite_q <= ex_mem_memWrite_d;
            ex_mem_memToReg_q <= ex_mem_memToReg_d;
            ex_mem_rd_q       <= ex_mem_rd_d;
            ex_mem_alu_q      <= ex_mem_alu_d;
            ex_mem_store_q    <= ex_mem_store_d;
            mem_wb_valid_q    <= mem_wb_valid_d;
            mem_wb_regWrite_q <= mem_wb_regWrite_d;
            mem_wb_rd_q       <= mem_wb_rd_d;
            mem_wb_data_q     <= mem_wb_data_d;
        end
    end

    // Forwarding-facing outputs come straight from flops.
    always_comb begin
        EX_MEM_regWrite  = ex_mem_valid_q & ex_mem_regWrite_q;
        EX_MEM_rd        = ex_mem_rd_q;
        EX_MEM_aluResult = ex_mem_alu_q;
        MEM_WB_regWrite  = mem_wb_valid_q & mem_wb_regWrite_q;
        MEM_WB_rd        = mem_wb_rd_q;
        MEM_WB_writeData = mem_wb_data_q;
    end

`ifdef EX_MEM_STALL_COUNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stalled cycles.
    always_comb begin
        if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Directed, table-driven bench for ex_mem_wb_pipe; stall counter checked when EX_MEM_STALL_COUNT_EN is defined.
module tb_ex_mem_wb_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg;
    logic [3:0]  ex_rd;
    logic [15:0] ex_aluResult, ex_storeData;
    logic        flush;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        mem_req, mem_we, ex_stall;
    logic [15:0] mem_addr, mem_wdata;
    logic        EX_MEM_regWrite, MEM_WB_regWrite;
    logic [3:0]  EX_MEM_rd, MEM_WB_rd;
    logic [15:0] EX_MEM_aluResult, MEM_WB_writeData;
`ifdef EX_MEM_STALL_COUNT_EN
    logic [15:0] stall_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ex_mem_wb_pipe #(.DATA_W(16), .REG_W(4)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
        .ex_memWrite(ex_memWrite), .ex_memToReg(ex_memToReg), .ex_rd(ex_rd),
        .ex_aluResult(ex_aluResult), .ex_storeData(ex_storeData), .flush(flush),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .ex_stall(ex_stall),
        .EX_MEM_regWrite(EX_MEM_regWrite), .EX_MEM_rd(EX_MEM_rd), .EX_MEM_aluResult(EX_MEM_aluResult),
        .MEM_WB_regWrite(MEM_WB_regWrite), .MEM_WB_rd(MEM_WB_rd), .MEM_WB_writeData(MEM_WB_writeData)
`ifdef EX_MEM_STALL_COUNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    typedef struct {
        logic        v, rw, fl;
        logic [3:0]  rd;
        logic [15:0] alu;
        logic        e_rw;
        logic [3:0]  e_rd;
        logic [15:0] e_alu;
        logic        w_rw;
        logic [3:0]  w_rd;
        logic [15:0] w_data;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic mr, input logic mw,
                         input logic m2r, input logic [3:0] rd, input logic [15:0] alu,
                         input logic [15:0] sd, input logic fl);
        ex_valid = v; ex_regWrite = rw; ex_memRead = mr; ex_memWrite = mw;
        ex_memToReg = m2r; ex_rd = rd; ex_aluResult = alu; ex_storeData = sd; flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 4'd5, 16'h1234, 1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 16'h0000};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 4'd7, 16'h00FF, 1'b1, 4'd7, 16'h00FF, 1'b1, 4'd5, 16'h1234};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 4'd9, 16'h0AAA, 1'b0, 4'd9, 16'h0AAA, 1'b1, 4'd7, 16'h00FF};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 4'd2, 16'h5555, 1'b0, 4'd2, 16'h5555, 1'b0, 4'd9, 16'h0AAA};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 4'd0, 16'h0001, 1'b0, 4'd0, 16'h0001, 1'b0, 4'd2, 16'h5555};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 4'd0, 16'hFFFF, 1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'h0001};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 16'hFFFF};

        // Reset with a live load being presented
        reset = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0000;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 16'h1234, 16'h9999, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_mem_req", {15'd0, mem_req}, 16'd0);
            chk("rst_ex_stall", {15'd0, ex_stall}, 16'd0);
            chk("rst_exmem_rw", {15'd0, EX_MEM_regWrite}, 16'd0);
            chk("rst_exmem_rd", {12'd0, EX_MEM_rd}, 16'd0);
            chk("rst_exmem_alu", EX_MEM_aluResult, 16'd0);
            chk("rst_memwb_rw", {15'd0, MEM_WB_regWrite}, 16'd0);
            chk("rst_memwb_rd", {12'd0, MEM_WB_rd}, 16'd0);
            chk("rst_memwb_data", MEM_WB_writeData, 16'd0);
            chk("rst_mem_addr", mem_addr, 16'd0);
        end
        reset = 1'b0;

        // Non-memory pipeline vectors
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].v, vecs[i].rw, 1'b0, 1'b0, 1'b0, vecs[i].rd, vecs[i].alu, 16'h0000, vecs[i].fl);
            tick();
            chk($sformatf("vec%0d_exmem_rw", i), {15'd0, EX_MEM_regWrite}, {15'd0, vecs[i].e_rw});
            chk($sformatf("vec%0d_exmem_rd", i), {12'd0, EX_MEM_rd}, {12'd0, vecs[i].e_rd});
            chk($sformatf("vec%0d_exmem_alu", i), EX_MEM_aluResult, vecs[i].e_alu);
            chk($sformatf("vec%0d_memwb_rw", i), {15'd0, MEM_WB_regWrite}, {15'd0, vecs[i].w_rw});
            chk($sformatf("vec%0d_memwb_rd", i), {12'd0, MEM_WB_rd}, {12'd0, vecs[i].w_rd});
            chk($sformatf("vec%0d_memwb_data", i), MEM_WB_writeData, vecs[i].w_data);
            chk($sformatf("vec%0d_req", i), {15'd0, mem_req}, 16'd0);
            chk($sformatf("vec%0d_stall", i), {15'd0, ex_stall}, 16'd0);
        end

        // Zero-wait load
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 16'h0040, 16'h0000, 1'b0);
        tick();
        chk("zw_req", {15'd0, mem_req}, 16'd1);
        chk("zw_we", {15'd0, mem_we}, 16'd0);
        chk("zw_addr", mem_addr, 16'h0040);
        chk("zw_stall", {15'd0, ex_stall}, 16'd0);
        idle();
        tick();
        chk("zw_req_drop", {15'd0, mem_req}, 16'd0);
        chk("zw_memwb_rw", {15'd0, MEM_WB_regWrite}, 16'd1);
        chk("zw_memwb_rd", {12'd0, MEM_WB_rd}, 16'd3);
        chk("zw_memwb_data", MEM_WB_writeData, 16'hBEEF);
        mem_ack = 1'b0; mem_rdata = 16'h0000;

        // Three-wait load with a following ALU instruction held in EX
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 16'h0080, 16'h0000, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 16'h7777, 16'h0000, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("w3_stall_c%0d", c), {15'd0, ex_stall}, 16'd1);
            chk($sformatf("w3_req_c%0d", c), {15'd0, mem_req}, 16'd1);
            chk($sformatf("w3_addr_c%0d", c), mem_addr, 16'h0080);
            chk($sformatf("w3_memwb_rw_c%0d", c), {15'd0, MEM_WB_regWrite}, 16'd0);
            chk($sformatf("w3_exmem_rd_c%0d", c), {12'd0, EX_MEM_rd}, 16'd4);
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 16'hCAFE;
        #1;
        chk("w3_req_c4", {15'd0, mem_req}, 16'd1);
        chk("w3_stall_c4", {15'd0, ex_stall}, 16'd0);
`ifdef EX_MEM_STALL_COUNT_EN
        chk("w3_stall_count", stall_cycles, 16'd3);
`endif
        tick();
        idle();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        chk("w3_memwb_rw", {15'd0, MEM_WB_regWrite}, 16'd1);
        chk("w3_memwb_rd", {12'd0, MEM_WB_rd}, 16'd4);
        chk("w3_memwb_data", MEM_WB_writeData, 16'hCAFE);
        chk("w3_exmem_rd_next", {12'd0, EX_MEM_rd}, 16'd6);
        chk("w3_exmem_rw_next", {15'd0, EX_MEM_regWrite}, 16'd1);
        tick();
        chk("w3_alu_memwb_rd", {12'd0, MEM_WB_rd}, 16'd6);
        chk("w3_alu_memwb_data", MEM_WB_writeData, 16'h7777);

        // Flush of a store, then a normal instruction
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd8, 16'h0100, 16'h1111, 1'b1);
        tick();
        chk("fl_exmem_rw", {15'd0, EX_MEM_regWrite}, 16'd0);
        chk("fl_req", {15'd0, mem_req}, 16'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 16'h0200, 16'h0000, 1'b0);
        tick();
        chk("fl_next_exmem_rw", {15'd0, EX_MEM_regWrite}, 16'd1);
        chk("fl_next_exmem_rd", {12'd0, EX_MEM_rd}, 16'd9);
        chk("fl_bubble_memwb_rw", {15'd0, MEM_WB_regWrite}, 16'd0);
        idle();
        tick();
        chk("fl_next_memwb_rw", {15'd0, MEM_WB_regWrite}, 16'd1);
        chk("fl_next_memwb_data", MEM_WB_writeData, 16'h0200);

        // Reset while a store waits, then a stray ack
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0300, 16'hABCD, 1'b0);
        tick();
        idle();
        chk("rw_req", {15'd0, mem_req}, 16'd1);
        chk("rw_we", {15'd0, mem_we}, 16'd1);
        chk("rw_wdata", mem_wdata, 16'hABCD);
        chk("rw_stall", {15'd0, ex_stall}, 16'd1);
        tick();
        chk("rw_addr_hold", mem_addr, 16'h0300);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rw_req_after_rst", {15'd0, mem_req}, 16'd0);
        chk("rw_stall_after_rst", {15'd0, ex_stall}, 16'd0);
        chk("rw_we_after_rst", {15'd0, mem_we}, 16'd0);
`ifdef EX_MEM_STALL_COUNT_EN
        chk("rw_count_cleared", stall_cycles, 16'd0);
`endif
        mem_ack = 1'b1; mem_rdata = 16'h5A5A;
        #1;
        chk("rw_stray_ack_stall", {15'd0, ex_stall}, 16'd0);
        tick();
        mem_ack = 1'b0;
        chk("rw_stray_req", {15'd0, mem_req}, 16'd0);
        chk("rw_stray_memwb_rw", {15'd0, MEM_WB_regWrite}, 16'd0);
        chk("rw_stray_exmem_rw", {15'd0, EX_MEM_regWrite}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
